// File: rtl/regfile_sweep.sv
// Three-port register file that clears itself after reset by writing regs[i] = i.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to a matching read port.
module regfile_sweep #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy
);

    localparam logic [AW:0]   NREGS_EXT = (AW+1)'(NREGS);
    localparam logic [AW-1:0] ZERO_IDX  = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    cnt_reg, cnt_next;

    logic             wr_en;
    logic             wr_ok;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The sweep and the user write share the single storage write port.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_addr    = wa3;
        wr_data    = wd3;
        case (state_reg)
            INIT: begin
                wr_en    = 1'b1;
                wr_addr  = cnt_reg;
                wr_data  = WIDTH'(cnt_reg);
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = READY;
                end
            end
            READY: begin
                wr_en = we3;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // The zero register has no storage behind it: its writes (including the
    // sweep's zero) are dropped and its reads are forced to 0.
    assign wr_ok = wr_en && !reset
                && ({1'b0, wr_addr} < NREGS_EXT)
                && (wr_addr != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign busy = (state_reg == INIT);

    logic [1:0][AW-1:0] ra_vec;
    assign ra_vec = {ra2, ra1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic             addr_ok;
            logic [WIDTH-1:0] rd_val;

            assign addr_ok = ({1'b0, ra_vec[gi]} < NREGS_EXT)
                          && (ra_vec[gi] != ZERO_IDX);

            always_comb begin
                rd_val = '0;
                if (!busy && addr_ok) begin
                    rd_val = regs[ra_vec[gi]];
`ifdef REGFILE_BYPASS_EN
                    if (we3 && (wa3 == ra_vec[gi])) begin
                        rd_val = wd3;
                    end
`endif
                end
            end
        end
    endgenerate

    assign rd1 = g_rd[0].rd_val;
    assign rd2 = g_rd[1].rd_val;

endmodule

// File: tb/tb_regfile_sweep.sv
// Randomised bench for regfile_sweep: a default instance (64x32, zero reg 31) and
// a 32-bit, 20-entry instance with zero reg 0, both checked against array models.
module tb_regfile_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  ra1a, ra2a, wa3a;
    logic [63:0] wd3a, rd1a, rd2a;
    logic        we3a, busya;
    logic [4:0]  ra1b, ra2b, wa3b;
    logic [31:0] wd3b, rd1b, rd2b;
    logic        we3b, busyb;

    regfile_sweep dut_a (
        .clk(clk), .reset(reset),
        .ra1(ra1a), .ra2(ra2a), .wa3(wa3a), .wd3(wd3a), .we3(we3a),
        .rd1(rd1a), .rd2(rd2a), .busy(busya)
    );

    regfile_sweep #(.WIDTH(32), .NREGS(20), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset),
        .ra1(ra1b), .ra2(ra2b), .wa3(wa3b), .wd3(wd3b), .we3(we3b),
        .rd1(rd1b), .rd2(rd2b), .busy(busyb)
    );

    int total = 0;
    int bad   = 0;

    // Model: register contents plus number of sweep cycles still to run.
    logic [63:0] ref_a [32];
    logic [31:0] ref_b [20];
    int left_a = 0;
    int left_b = 0;

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            left_a = 32;
            left_b = 20;
        end else begin
            if (left_a > 0) begin
                int i;
                i = 32 - left_a;
                ref_a[i] = (i == 31) ? 64'd0 : 64'(i);
                left_a--;
            end else if (we3a && wa3a != 5'd31) begin
                ref_a[wa3a] = wd3a;
            end
            if (left_b > 0) begin
                int j;
                j = 20 - left_b;
                ref_b[j] = (j == 0) ? 32'd0 : 32'(j);
                left_b--;
            end else if (we3b && wa3b < 5'd20 && wa3b != 5'd0) begin
                ref_b[wa3b] = wd3b;
            end
        end
        #1;
    endtask

    function automatic logic [63:0] exp_a(input logic [4:0] ra);
        if (left_a > 0 || ra == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we3a && wa3a == ra) return wd3a;
`endif
        return ref_a[ra];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] ra);
        if (left_b > 0 || ra >= 5'd20 || ra == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we3b && wa3b == ra) return wd3b;
`endif
        return ref_b[ra];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        we3a = 0; wa3a = 0; wd3a = 0; ra1a = 0; ra2a = 0;
        we3b = 0; wa3b = 0; wd3b = 0; ra1b = 0; ra2b = 0;
        tick();
        tick();
        reset = 1'b0;
        ra1a = 5'd5; ra2a = 5'd30; ra1b = 5'd5;
        #1;
        total++;
        if (busya !== 1'b1 || busyb !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy got a=%b b=%b exp 1", busya, busyb);
        end
        total++;
        if (rd1a !== 64'd0 || rd2a !== 64'd0 || rd1b !== 32'd0) begin
            bad++;
            $display("FAIL reset_rd got %h %h %h exp 0", rd1a, rd2a, rd1b);
        end
        $display("reset applied");
    endtask

    task automatic test_sweep();
        int na = 0;
        int nb = 0;
        for (int c = 0; c < 64; c++) begin
            ra1a = 5'($urandom); ra2a = 5'($urandom);
            ra1b = 5'($urandom); ra2b = 5'($urandom);
            we3a = (left_a > 0) ? 1'($urandom) : 1'b0;
            wa3a = 5'($urandom); wd3a = {$urandom, $urandom};
            we3b = (left_b > 0) ? 1'($urandom) : 1'b0;
            wa3b = 5'($urandom); wd3b = $urandom;
            if (c == 1) begin
                we3a = 1'b1; wa3a = 5'd2; wd3a = 64'hFF;
            end
            #1;
            total++;
            if (busya !== (left_a > 0) || busyb !== (left_b > 0)) begin
                bad++;
                $display("FAIL sweep_busy c=%0d got a=%b b=%b exp a=%b b=%b",
                         c, busya, busyb, left_a > 0, left_b > 0);
            end
            total++;
            if (rd1a !== exp_a(ra1a) || rd2a !== exp_a(ra2a)
                || rd1b !== exp_b(ra1b) || rd2b !== exp_b(ra2b)) begin
                bad++;
                $display("FAIL sweep_rd c=%0d got %h %h %h %h exp %h %h %h %h", c,
                         rd1a, rd2a, rd1b, rd2b,
                         exp_a(ra1a), exp_a(ra2a), exp_b(ra1b), exp_b(ra2b));
            end
            if (busya) na++;
            if (busyb) nb++;
            tick();
        end
        total++;
        if (na != 32 || nb != 20) begin
            bad++;
            $display("FAIL sweep_len got a=%0d b=%0d exp a=32 b=20", na, nb);
        end
        $display("sweep: busy a=%0d b=%0d cycles", na, nb);
    endtask

    task automatic test_contents(input string tag);
        we3a = 1'b0; we3b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1a = 5'(i); ra2a = 5'(31 - i);
            ra1b = 5'(i); ra2b = 5'(i);
            #1;
            total++;
            if (rd1a !== ((i == 31) ? 64'd0 : 64'(i))
                || rd2a !== ((i == 0) ? 64'd0 : 64'(31 - i))) begin
                bad++;
                $display("FAIL %s_a i=%0d got %h %h exp %0d %0d", tag, i, rd1a, rd2a,
                         (i == 31) ? 0 : i, (i == 0) ? 0 : 31 - i);
            end
            total++;
            if (rd1b !== ((i == 0 || i >= 20) ? 32'd0 : 32'(i)) || rd2b !== rd1b) begin
                bad++;
                $display("FAIL %s_b i=%0d got %h %h exp %0d", tag, i, rd1b, rd2b,
                         (i == 0 || i >= 20) ? 0 : i);
            end
            tick();
        end
        $display("%s: contents checked", tag);
    endtask

    task automatic test_bypass();
        we3a = 1'b1; wa3a = 5'd7; ra1a = 5'd7; ra2a = 5'd7; wd3a = 64'hAA;
        #1;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (rd1a !== 64'hAA || rd2a !== 64'hAA) begin
            bad++;
            $display("FAIL bypass_same got %h %h exp aa", rd1a, rd2a);
        end
`else
        if (rd1a !== 64'd7 || rd2a !== 64'd7) begin
            bad++;
            $display("FAIL bypass_same got %h %h exp 7", rd1a, rd2a);
        end
`endif
        tick();
        we3a = 1'b0;
        #1;
        total++;
        if (rd1a !== 64'hAA || rd2a !== 64'hAA) begin
            bad++;
            $display("FAIL bypass_next got %h %h exp aa", rd1a, rd2a);
        end
        $display("wr a addr=7 data=aa");
    endtask

    task automatic test_write();
        we3a = 1'b1; wa3a = 5'd3; wd3a = 64'hDEAD; ra1a = 5'd3;
        tick();
        we3a = 1'b1; wa3a = 5'd31; wd3a = 64'h1234; ra2a = 5'd31;
        #1;
        total++;
        if (rd1a !== 64'hDEAD) begin
            bad++;
            $display("FAIL write_dead got %h exp dead", rd1a);
        end
        tick();
        we3a = 1'b0;
        #1;
        total++;
        if (rd2a !== 64'd0) begin
            bad++;
            $display("FAIL write_zero_reg got %h exp 0", rd2a);
        end
        $display("wr a addr=3 data=dead; wr a addr=31 data=1234");
        for (int c = 0; c < 200; c++) begin
            we3a = 1'($urandom); wa3a = 5'($urandom); wd3a = {$urandom, $urandom};
            ra1a = ($urandom_range(0, 3) == 0) ? wa3a : 5'($urandom);
            ra2a = 5'($urandom);
            we3b = 1'($urandom); wa3b = 5'($urandom); wd3b = $urandom;
            ra1b = ($urandom_range(0, 3) == 0) ? wa3b : 5'($urandom);
            ra2b = 5'($urandom);
            #1;
            total++;
            if (rd1a !== exp_a(ra1a) || rd2a !== exp_a(ra2a)) begin
                bad++;
                $display("FAIL rand_a c=%0d ra=%0d/%0d got %h %h exp %h %h", c, ra1a, ra2a,
                         rd1a, rd2a, exp_a(ra1a), exp_a(ra2a));
            end
            total++;
            if (rd1b !== exp_b(ra1b) || rd2b !== exp_b(ra2b)) begin
                bad++;
                $display("FAIL rand_b c=%0d ra=%0d/%0d got %h %h exp %h %h", c, ra1b, ra2b,
                         rd1b, rd2b, exp_b(ra1b), exp_b(ra2b));
            end
            if (we3a) $display("wr a addr=%0d data=%h", wa3a, wd3a);
            if (we3b) $display("wr b addr=%0d data=%h", wa3b, wd3b);
            tick();
        end
        we3a = 1'b0; we3b = 1'b0;
    endtask

    task automatic test_mid_reset();
        int na = 0;
        int nb = 0;
        we3a = 1'b0; we3b = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        reset = 1'b1;
        #1;
        total++;
        if (busya !== 1'b1 || rd1a !== 64'd0) begin
            bad++;
            $display("FAIL midreset_hold got busy=%b rd1=%h exp 1 0", busya, rd1a);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 64 && (busya || busyb); c++) begin
            if (busya) na++;
            if (busyb) nb++;
            tick();
        end
        total++;
        if (na != 32 || nb != 20 || busya !== 1'b0 || busyb !== 1'b0) begin
            bad++;
            $display("FAIL midreset_len got a=%0d b=%0d exp a=32 b=20", na, nb);
        end
        $display("mid-sweep reset: busy a=%0d b=%0d cycles", na, nb);
    endtask

    task automatic test_params();
        ra1b = 5'd25; ra2b = 5'd0;
        #1;
        total++;
        if (rd1b !== 32'd0 || rd2b !== 32'd0) begin
            bad++;
            $display("FAIL param_oob_rd got %h %h exp 0", rd1b, rd2b);
        end
        we3b = 1'b1; wa3b = 5'd25; wd3b = 32'hCAFE_F00D;
        tick();
        wa3b = 5'd0; wd3b = 32'h5555_AAAA;
        tick();
        we3b = 1'b0;
        #1;
        total++;
        if (rd1b !== 32'd0 || rd2b !== 32'd0) begin
            bad++;
            $display("FAIL param_drop got %h %h exp 0", rd1b, rd2b);
        end
        ra1b = 5'd19; ra2b = 5'd25;
        #1;
        total++;
        if (rd1b !== 32'd19 || rd2b !== 32'd0) begin
            bad++;
            $display("FAIL param_last got %h %h exp 13 0", rd1b, rd2b);
        end
        $display("wr b addr=25 dropped; wr b addr=0 dropped");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_contents("sweep");
        test_bypass();
        test_write();
        test_mid_reset();
        test_contents("midreset");
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
